hog_block_assembler: RTL and testbench

- Downstream neighbour of the cell histogram stage. Consumes 8x8-cell histograms in raster order and emits overlapping 2x2-cell HOG blocks with a 1-cell stride.
- Keeps one cell row of histograms in a line buffer and produces the block-wide sum of the per-cell sum bins.
- Output feeds the block normalisation stage.

---
 rtl/hog_pkg.sv | 20 ++
 rtl/cell_row_buffer.sv | 26 ++
 rtl/hog_block_assembler.sv | 154 +++++++++++++++
 tb/tb_hog_block_assembler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hog_pkg.sv
// Shared HOG definitions: cell geometry, histogram layout and counter sizing helpers.
package hog_pkg;

   localparam int CELL_SIZE        = 8;
   localparam int BINS             = 10;
   localparam int SUM_BIN          = 9;
   localparam int OUTPUT_BIN_WIDTH = 14;

   typedef logic [BINS-1:0][OUTPUT_BIN_WIDTH-1:0] hist_t;

   function automatic int cells(input int pixels);
      return pixels / CELL_SIZE;
   endfunction

   // A counter over a single value still needs one bit.
   function automatic int cnt_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/cell_row_buffer.sv
// One row of cell histograms: combinational read-first port, synchronous write.
module cell_row_buffer
   import hog_pkg::*;
#(
   parameter int DEPTH = 80,
   parameter int WIDTH = 140
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [cnt_width(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]            wr_data,
   output logic [WIDTH-1:0]            rd_data
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   assign rd_data = mem_r[addr];

   // Histogram write for the current column; the old entry is read in the same cycle.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/hog_block_assembler.sv
// Builds overlapping 2x2-cell HOG blocks (stride 1 cell) from raster-ordered cell histograms.
// Optional BLOCK_LAST_EN adds out_last, flagging the final block of each frame.
module hog_block_assembler #(
   parameter int OUTPUT_BIN_WIDTH = hog_pkg::OUTPUT_BIN_WIDTH,
   parameter int BINS             = hog_pkg::BINS,
   parameter int HISTOGRAM_WIDTH  = OUTPUT_BIN_WIDTH * BINS,
   parameter int IMAGE_WIDTH      = 640,
   parameter int IMAGE_HEIGHT     = 480,
   parameter int SUM_WIDTH        = OUTPUT_BIN_WIDTH + 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [HISTOGRAM_WIDTH-1:0]   histogram,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [4*HISTOGRAM_WIDTH-1:0] block,
   output logic [SUM_WIDTH-1:0]         block_sum
`ifdef BLOCK_LAST_EN
   ,
   output logic                         out_last
`endif
);

   import hog_pkg::*;

   localparam int CELLS_PER_ROW = cells(IMAGE_WIDTH);
   localparam int CELL_ROWS     = cells(IMAGE_HEIGHT);
   localparam int COL_W         = cnt_width(CELLS_PER_ROW);
   localparam int ROW_W         = cnt_width(CELL_ROWS);
   localparam int BLOCK_WIDTH   = 4 * HISTOGRAM_WIDTH;
   localparam int SUM_LSB       = SUM_BIN * OUTPUT_BIN_WIDTH;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELLS_PER_ROW - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CELL_ROWS - 1);

   logic [COL_W-1:0]           col_r;
   logic [ROW_W-1:0]           row_r;
   logic [COL_W-1:0]           col_next_s;
   logic [ROW_W-1:0]           row_next_s;
   logic [HISTOGRAM_WIDTH-1:0] tl_r;
   logic [HISTOGRAM_WIDTH-1:0] left_r;
   logic [HISTOGRAM_WIDTH-1:0] top_s;
   logic                       in_ready_s;
   logic                       accept_s;
   logic                       emit_s;
   logic [BLOCK_WIDTH-1:0]     cand_block_s;
   logic [SUM_WIDTH-1:0]       cand_sum_s;
   logic                       out_valid_r;
   logic [BLOCK_WIDTH-1:0]     block_r;
   logic [SUM_WIDTH-1:0]       block_sum_r;
`ifdef BLOCK_LAST_EN
   logic                       last_s;
   logic                       out_last_r;
`endif

   function automatic logic [SUM_WIDTH-1:0] sum_field(input logic [HISTOGRAM_WIDTH-1:0] h);
      return SUM_WIDTH'(h[SUM_LSB +: OUTPUT_BIN_WIDTH]);
   endfunction

   // The output register frees up either when empty or when its block is taken this cycle.
   assign in_ready_s = !out_valid_r || out_ready;
   assign accept_s   = in_valid && in_ready_s;
   assign emit_s     = accept_s && (row_r != {ROW_W{1'b0}}) && (col_r != {COL_W{1'b0}});

   cell_row_buffer #(
      .DEPTH (CELLS_PER_ROW),
      .WIDTH (HISTOGRAM_WIDTH)
   ) u_row_buffer (
      .clk     (clk),
      .wr_en   (accept_s),
      .addr    (col_r),
      .wr_data (histogram),
      .rd_data (top_s)
   );

   assign cand_block_s = {histogram, left_r, top_s, tl_r};
   assign cand_sum_s   = sum_field(histogram) + sum_field(left_r)
                       + sum_field(top_s) + sum_field(tl_r);

`ifdef BLOCK_LAST_EN
   assign last_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
`endif

   // Raster position of the next cell; wraps straight into the next frame.
   always_comb begin
      col_next_s = col_r;
      row_next_s = row_r;
      if (accept_s) begin
         if (col_r == COL_LAST) begin
            col_next_s = {COL_W{1'b0}};
            if (row_r == ROW_LAST) begin
               row_next_s = {ROW_W{1'b0}};
            end else begin
               row_next_s = row_r + ROW_W'(1);
            end
         end else begin
            col_next_s = col_r + COL_W'(1);
            row_next_s = row_r;
         end
      end else begin
         col_next_s = col_r;
         row_next_s = row_r;
      end
   end

   // Position counters and the left/top-left neighbours of the incoming cell.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r  <= {COL_W{1'b0}};
         row_r  <= {ROW_W{1'b0}};
         tl_r   <= {HISTOGRAM_WIDTH{1'b0}};
         left_r <= {HISTOGRAM_WIDTH{1'b0}};
      end else begin
         col_r <= col_next_s;
         row_r <= row_next_s;
         if (accept_s) begin
            tl_r   <= top_s;
            left_r <= histogram;
         end
      end
   end

   // Single output stage: holds under stall, reloads in the same cycle the old block leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         block_r     <= {BLOCK_WIDTH{1'b0}};
         block_sum_r <= {SUM_WIDTH{1'b0}};
`ifdef BLOCK_LAST_EN
         out_last_r  <= 1'b0;
`endif
      end else if (in_ready_s) begin
         out_valid_r <= emit_s;
         if (emit_s) begin
            block_r     <= cand_block_s;
            block_sum_r <= cand_sum_s;
`ifdef BLOCK_LAST_EN
            out_last_r  <= last_s;
`endif
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign block     = block_r;
   assign block_sum = block_sum_r;
`ifdef BLOCK_LAST_EN
   assign out_last  = out_last_r;
`endif

endmodule

// File: tb/tb_hog_block_assembler.sv
// Self-checking bench for hog_block_assembler on a 4x3-cell image; cell n has every bin = n.
`timescale 1ns/1ps
module tb_hog_block_assembler;

   localparam int OBW    = 14;
   localparam int NB     = 10;
   localparam int HW     = OBW * NB;
   localparam int BW     = 4 * HW;
   localparam int SW     = OBW + 2;
   localparam int NCELLS = 12;
   localparam int MAXV   = (1 << OBW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [HW-1:0] histogram;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] block;
   logic [SW-1:0] block_sum;
   logic          out_last;

   typedef struct {
      int val;
      bit emit;
      int tl, tr, bl, br;
      int sum;
      bit last;
   } vec_t;

   typedef struct {
      logic [BW-1:0] blk;
      logic [SW-1:0] sum;
      bit            last;
   } exp_t;

   vec_t tbl [NCELLS];
   exp_t exp_q [$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cnt, acc5_cyc, first_rise, n_out, ready_drop;
   logic ov_prev = 1'b0;

   hog_block_assembler #(
      .IMAGE_WIDTH  (32),
      .IMAGE_HEIGHT (24)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .histogram (histogram),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .block     (block),
      .block_sum (block_sum)
`ifdef BLOCK_LAST_EN
      ,
      .out_last  (out_last)
`endif
   );

`ifndef BLOCK_LAST_EN
   assign out_last = 1'b0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [HW-1:0] fill(input int v);
      logic [HW-1:0] h;
      for (int k = 0; k < NB; k++) h[k*OBW +: OBW] = v[OBW-1:0];
      return h;
   endfunction

   function automatic logic [BW-1:0] make_block(input int tl, input int tr, input int bl, input int br);
      return {fill(br), fill(bl), fill(tr), fill(tl)};
   endfunction

   function automatic vec_t mk(input int v, input bit em, input int tl, input int tr,
                               input int bl, input int br, input int s, input bit l);
      vec_t r;
      r.val = v; r.emit = em; r.tl = tl; r.tr = tr; r.bl = bl; r.br = br; r.sum = s; r.last = l;
      return r;
   endfunction

   task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic clear_stats();
      acc_cnt    = 0;
      acc5_cyc   = -1;
      first_rise = -1;
      n_out      = 0;
      ready_drop = 0;
   endtask

   // Scoreboard and timing monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            if (acc_cnt == 5) acc5_cyc = cyc;
            acc_cnt++;
         end
         if (out_valid && !ov_prev && first_rise < 0) first_rise = cyc;
         if (out_ready && !in_ready) ready_drop++;
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_block got=%0h want=none", block);
            end else begin
               mon_e = exp_q.pop_front();
               check("block", block, mon_e.blk);
               check("block_sum", BW'(block_sum), BW'(mon_e.sum));
`ifdef BLOCK_LAST_EN
               check("out_last", BW'(out_last), BW'(mon_e.last));
`endif
            end
         end
      end
      ov_prev = out_valid;
   end

   task automatic send_cell(input int v);
      int n;
      n = 0;
      in_valid  = 1'b1;
      histogram = fill(v);
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_ready", BW'(in_ready), BW'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int ncells, input bit maxv);
      exp_t x;
      for (int i = 0; i < ncells; i++) begin
         if (tbl[i].emit) begin
            x.blk  = maxv ? {BW{1'b1}} : make_block(tbl[i].tl, tbl[i].tr, tbl[i].bl, tbl[i].br);
            x.sum  = maxv ? SW'(4 * MAXV) : SW'(tbl[i].sum);
            x.last = tbl[i].last;
            exp_q.push_back(x);
         end
         send_cell(maxv ? MAXV : tbl[i].val);
      end
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      histogram = '0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("queue_empty", BW'(exp_q.size()), BW'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = mk(0,  1'b0, 0, 0, 0, 0,  0,  1'b0);
      tbl[1]  = mk(1,  1'b0, 0, 0, 0, 0,  0,  1'b0);
      tbl[2]  = mk(2,  1'b0, 0, 0, 0, 0,  0,  1'b0);
      tbl[3]  = mk(3,  1'b0, 0, 0, 0, 0,  0,  1'b0);
      tbl[4]  = mk(4,  1'b0, 0, 0, 0, 0,  0,  1'b0);
      tbl[5]  = mk(5,  1'b1, 0, 1, 4, 5,  10, 1'b0);
      tbl[6]  = mk(6,  1'b1, 1, 2, 5, 6,  14, 1'b0);
      tbl[7]  = mk(7,  1'b1, 2, 3, 6, 7,  18, 1'b0);
      tbl[8]  = mk(8,  1'b0, 0, 0, 0, 0,  0,  1'b0);
      tbl[9]  = mk(9,  1'b1, 4, 5, 8, 9,  26, 1'b0);
      tbl[10] = mk(10, 1'b1, 5, 6, 9, 10, 30, 1'b0);
      tbl[11] = mk(11, 1'b1, 6, 7, 10, 11, 34, 1'b1);

      rst       = 1'b1;
      in_valid  = 1'b0;
      histogram = '0;
      out_ready = 1'b1;
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", BW'(out_valid), BW'(0));
      check("rst_block", block, '0);
      check("rst_block_sum", BW'(block_sum), BW'(0));
      check("rst_in_ready", BW'(in_ready), BW'(1));
`ifdef BLOCK_LAST_EN
      check("rst_out_last", BW'(out_last), BW'(0));
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single frame with continuous input and no back-pressure.
      clear_stats();
      run_frame(NCELLS, 1'b0);
      idle();
      wait_drain();
      check("s1_count", BW'(n_out), BW'(6));
      check("s1_latency", BW'(first_rise - acc5_cyc), BW'(1));
      check("s1_in_ready_drop", BW'(ready_drop), BW'(0));

      // Back-pressure: first block held for 5 cycles.
      clear_stats();
      out_ready = 1'b0;
      fork
         run_frame(NCELLS, 1'b0);
         begin
            int n;
            n = 0;
            while (!out_valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            check("bp_valid", BW'(out_valid), BW'(1));
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("bp_in_ready", BW'(in_ready), BW'(0));
               check("bp_hold_block", block, make_block(0, 1, 4, 5));
               check("bp_hold_sum", BW'(block_sum), BW'(10));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      idle();
      wait_drain();
      check("s2_count", BW'(n_out), BW'(6));

      // Two frames back to back.
      clear_stats();
      run_frame(NCELLS, 1'b0);
      run_frame(NCELLS, 1'b0);
      idle();
      wait_drain();
      check("s3_count", BW'(n_out), BW'(12));

      // Saturated bins.
      clear_stats();
      run_frame(NCELLS, 1'b1);
      idle();
      wait_drain();
      check("s4_count", BW'(n_out), BW'(6));

      // Reset mid-frame after cell 6 with a block pending at the output.
      clear_stats();
      run_frame(7, 1'b0);
      out_ready = 1'b0;
      idle();
      #2;
      check("pre_rst_valid", BW'(out_valid), BW'(1));
      rst = 1'b1;
      #1;
      check("arst_out_valid", BW'(out_valid), BW'(0));
      check("arst_block", block, '0);
      check("arst_block_sum", BW'(block_sum), BW'(0));
      check("arst_pending", BW'(exp_q.size()), BW'(1));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      clear_stats();
      run_frame(NCELLS, 1'b0);
      idle();
      wait_drain();
      check("s5_count", BW'(n_out), BW'(6));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
